mano_io_port: RTL and testbench
===============================

Name: mano_io_port

Overview:
- Memory-mapped-style I/O stage for the Mano basic computer.
- Sits beside the `computer` core; supplies INPR/FGI to the core's INP/SKI instructions and consumes OUTR/FGO from its OUT/SKO instructions.
- Owns the IEN flip-flop and the interrupt request consumed by the core's interrupt cycle (R flag).
- Bridges both registers to external character devices through valid/ready handshakes, with output pacing that models a slow printer.

Parameters:
- DW, 8, character width; INPR/OUTR width, matches AC[7:0].
- OUT_LATENCY, 4, idle cycles after an output-device handshake before FGO is set again; legal range 0..255.

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  reset, asynchronous, active-high
- enable  in  1  global step enable; when 0 all state holds and no transfer occurs
- cpu_inp  in  1  INP strobe; one cycle
- cpu_out  in  1  OUT strobe; one cycle
- cpu_ion  in  1  ION strobe
- cpu_iof  in  1  IOF strobe
- cpu_int_ack  in  1  interrupt cycle taken; clears IEN
- ac_low  in  DW  AC[7:0], sampled on cpu_out
- inpr_o  out  DW  INPR contents; the core loads these into AC[7:0] on INP
- fgi_o  out  1  input flag, used by SKI
- fgo_o  out  1  output flag, used by SKO
- ien_o  out  1  interrupt enable
- irq_o  out  1  IEN & (FGI | FGO)
- dev_in_data  in  DW  input-device character
- dev_in_valid  in  1  input-device character valid
- dev_in_ready  out  1  equals ~FGI & enable
- dev_out_data  out  DW  equals OUTR
- dev_out_valid  out  1  (state==SEND) & enable
- dev_out_ready  in  1  output device accepts the character

Behaviour:
- Reset (clr=1, async) sets INPR=0, OUTR=0, FGI=0, FGO=1, IEN=0, state=IDLE, pace counter=0.
- Resulting reset outputs: irq_o=0, dev_out_valid=0, dev_in_ready=enable.
- Reset mid-transfer abandons the transfer; no partial state survives.
- All updates occur on the rising clk edge with enable=1. With enable=0, registers, state and counter all hold.
- Input path:
  - Handshake completes when dev_in_valid & dev_in_ready. It loads INPR<=dev_in_data and sets FGI<=1.
  - cpu_inp with FGI=1 clears FGI next cycle; inpr_o is still valid in the strobe cycle.
  - cpu_inp with FGI=0 has no effect.
  - If cpu_inp (FGI=0) coincides with an input handshake, the load wins and FGI=1.
- Output FSM, states IDLE, SEND, PACE:
  - IDLE: FGO=1. On cpu_out, OUTR<=ac_low, FGO<=0, go to SEND.
  - SEND: dev_out_valid=1; dev_out_data stays stable until accepted. On dev_out_ready: if OUT_LATENCY=0, FGO<=1 and go to IDLE; otherwise counter<=OUT_LATENCY-1 and go to PACE.
  - PACE: counter decrements each enabled cycle. At 0, FGO<=1 and go to IDLE.
  - cpu_out while FGO=0 (SEND or PACE) is ignored; OUTR is unchanged.
- Latency:
  - cpu_out to dev_out_valid: 1 cycle.
  - Accept to FGO=1: OUT_LATENCY+1 cycles (1 when OUT_LATENCY=0).
- Interrupt enable:
  - cpu_ion sets IEN; cpu_iof clears IEN.
  - Priority when simultaneous: cpu_int_ack > cpu_iof > cpu_ion.
  - irq_o is combinational from registers; glitch-free relative to clk.
- Simultaneous cpu_inp and cpu_out are both honoured independently.

Optional Feature:
- MANO_IO_LOOPBACK_EN defined: adds input port loop_sel (1 bit).
  - With loop_sel=1, the SEND state completes internally instead of using the device handshake.
  - If FGI=0: INPR<=OUTR, FGI<=1, then proceed exactly as on a dev_out_ready accept.
  - If FGI=1: SEND holds until FGI clears.
  - With loop_sel=1, dev_out_valid=0 and dev_in_ready=0.
- MANO_IO_LOOPBACK_EN undefined: no loop_sel port; device paths only.

Test Plan:
- Reset: assert clr for 3 ns asynchronously mid-cycle -> immediately FGI=0, FGO=1, IEN=0, irq_o=0, inpr_o=0x00, dev_out_valid=0.
- Input: dev_in_data=0x41 with valid for 1 cycle -> FGI=1, inpr_o=0x41, dev_in_ready=0. A second valid with 0x42 is not accepted. cpu_inp -> FGI=0 next cycle; then 0x42 is accepted.
- Output with OUT_LATENCY=4: cpu_out with ac_low=0x5A -> next cycle dev_out_valid=1, data=0x5A, FGO=0. Hold dev_out_ready=0 for 10 cycles -> data stays stable and a cpu_out with 0x33 is ignored. Ready for 1 cycle -> FGO=1 exactly 5 cycles later.
- Interrupt: cpu_ion with FGO=1 -> irq_o=1. cpu_int_ack together with cpu_ion -> IEN=0 and irq_o=0. cpu_iof together with cpu_ion -> IEN=0.
- Enable freeze: enable=0 while in PACE with counter=2, held for 20 cycles -> counter, FGO and dev_in_ready=0 all held. Re-enable -> FGO=1 after 3 cycles.
- Loopback (MANO_IO_LOOPBACK_EN, loop_sel=1): cpu_out with 0x7E -> FGI=1 and inpr_o=0x7E after 2 cycles, with no dev_out_valid pulse.

Source files
------------

// File: rtl/mano_io_port_if.sv
// Bus bundle between the Mano core, the I/O port and the external character devices.
// The slave modport is the I/O port's view; the master modport is the core and device side.
interface mano_io_port_if #(
    parameter int unsigned DW = 8
);
    logic          cpu_inp;
    logic          cpu_out;
    logic          cpu_ion;
    logic          cpu_iof;
    logic          cpu_int_ack;
    logic [DW-1:0] ac_low;
    logic [DW-1:0] inpr_o;
    logic          fgi_o;
    logic          fgo_o;
    logic          ien_o;
    logic          irq_o;
    logic [DW-1:0] dev_in_data;
    logic          dev_in_valid;
    logic          dev_in_ready;
    logic [DW-1:0] dev_out_data;
    logic          dev_out_valid;
    logic          dev_out_ready;

    modport slave (
        input  cpu_inp, cpu_out, cpu_ion, cpu_iof, cpu_int_ack, ac_low,
        input  dev_in_data, dev_in_valid, dev_out_ready,
        output inpr_o, fgi_o, fgo_o, ien_o, irq_o,
        output dev_in_ready, dev_out_data, dev_out_valid
    );

    modport master (
        output cpu_inp, cpu_out, cpu_ion, cpu_iof, cpu_int_ack, ac_low,
        output dev_in_data, dev_in_valid, dev_out_ready,
        input  inpr_o, fgi_o, fgo_o, ien_o, irq_o,
        input  dev_in_ready, dev_out_data, dev_out_valid
    );
endinterface

// File: rtl/mano_io_port.sv
// Mano basic-computer I/O stage: INPR/FGI, OUTR/FGO with printer pacing, IEN and IRQ.
// Define MANO_IO_LOOPBACK_EN to add loop_sel, which routes OUTR back into INPR internally.
module mano_io_port #(
    parameter int unsigned DW          = 8,
    parameter int unsigned OUT_LATENCY = 4
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          enable,
`ifdef MANO_IO_LOOPBACK_EN
    input  logic          loop_sel,
`endif
    mano_io_port_if.slave io
);
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        PACE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] inpr_q, inpr_d;
    logic [DW-1:0] outr_q, outr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fgi_q, fgi_d;
    logic          fgo_q, fgo_d;
    logic          ien_q, ien_d;
    logic          loop_c;
    logic          dev_in_ready_c;
    logic          dev_out_valid_c;
    logic          in_hs_c;
    logic          loop_go_c;
    logic          out_acc_c;

`ifdef MANO_IO_LOOPBACK_EN
    assign loop_c = loop_sel;
`else
    assign loop_c = 1'b0;
`endif

    assign dev_in_ready_c = ~fgi_q & enable & ~loop_c;
    assign in_hs_c        = io.dev_in_valid & dev_in_ready_c;
    // Loopback can only complete once the CPU has drained the previous input character.
    assign loop_go_c      = enable & (state_q == SEND) & loop_c & ~fgi_q;
    assign out_acc_c      = enable & (state_q == SEND) & (loop_c ? ~fgi_q : io.dev_out_ready);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (enable) begin
            unique case (state_q)
                IDLE:    if (io.cpu_out) state_d = SEND;
                SEND:    if (out_acc_c) state_d = (OUT_LATENCY == 0) ? IDLE : PACE;
                PACE:    if (cnt_q == '0) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        outr_d          = outr_q;
        cnt_d           = cnt_q;
        fgo_d           = fgo_q;
        dev_out_valid_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable && io.cpu_out) begin
                    outr_d = io.ac_low;
                    fgo_d  = 1'b0;
                end
            end
            SEND: begin
                dev_out_valid_c = enable & ~loop_c;
                if (out_acc_c) begin
                    if (OUT_LATENCY == 0) fgo_d = 1'b1;
                    else                  cnt_d = CW'(OUT_LATENCY - 1);
                end
            end
            PACE: begin
                if (enable) begin
                    if (cnt_q == '0) fgo_d = 1'b1;
                    else             cnt_d = cnt_q - CW'(1);
                end
            end
            default: ;
        endcase
    end

    // Input flag, INPR and interrupt enable; a device load always beats a same-cycle INP.
    always_comb begin
        inpr_d = inpr_q;
        fgi_d  = fgi_q;
        ien_d  = ien_q;
        if (in_hs_c) begin
            inpr_d = io.dev_in_data;
            fgi_d  = 1'b1;
        end else if (loop_go_c) begin
            inpr_d = outr_q;
            fgi_d  = 1'b1;
        end else if (enable && io.cpu_inp && fgi_q) begin
            fgi_d  = 1'b0;
        end
        if (enable) begin
            if (io.cpu_int_ack || io.cpu_iof) ien_d = 1'b0;
            else if (io.cpu_ion)              ien_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            inpr_q <= '0;
            outr_q <= '0;
            cnt_q  <= '0;
            fgi_q  <= 1'b0;
            fgo_q  <= 1'b1;
            ien_q  <= 1'b0;
        end else begin
            inpr_q <= inpr_d;
            outr_q <= outr_d;
            cnt_q  <= cnt_d;
            fgi_q  <= fgi_d;
            fgo_q  <= fgo_d;
            ien_q  <= ien_d;
        end
    end

    assign io.inpr_o        = inpr_q;
    assign io.fgi_o         = fgi_q;
    assign io.fgo_o         = fgo_q;
    assign io.ien_o         = ien_q;
    assign io.irq_o         = ien_q & (fgi_q | fgo_q);
    assign io.dev_in_ready  = dev_in_ready_c;
    assign io.dev_out_data  = outr_q;
    assign io.dev_out_valid = dev_out_valid_c;
endmodule

// File: tb/tb_mano_io_port.sv
// Self-checking bench for mano_io_port: directed scenarios plus random traffic against a flag-level model.
// Loopback scenarios are included when MANO_IO_LOOPBACK_EN is defined.
module tb_mano_io_port;
    localparam int unsigned DW          = 8;
    localparam int unsigned OUT_LATENCY = 4;

    logic clk;
    logic clr;
    logic enable;
    logic lsel;

    int checks;
    int errors;

    // Reference model: flags, registers and "edges until FGO returns".
    logic [7:0] m_inpr, m_outr;
    logic       m_fgi, m_fgo, m_ien, m_sending;
    int         m_wait;

    mano_io_port_if #(.DW(DW)) io ();

    mano_io_port #(.DW(DW), .OUT_LATENCY(OUT_LATENCY)) dut (
        .clk      (clk),
        .clr      (clr),
        .enable   (enable),
`ifdef MANO_IO_LOOPBACK_EN
        .loop_sel (lsel),
`endif
        .io       (io)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic void model_reset();
        m_inpr = 8'h00; m_outr = 8'h00;
        m_fgi = 1'b0; m_fgo = 1'b1; m_ien = 1'b0; m_sending = 1'b0;
        m_wait = 0;
    endfunction

    function automatic logic [21:0] dut_vec();
        return {io.inpr_o, io.fgi_o, io.fgo_o, io.ien_o, io.irq_o,
                io.dev_in_ready, io.dev_out_valid, io.dev_out_data};
    endfunction

    function automatic logic [21:0] exp_vec();
        return {m_inpr, m_fgi, m_fgo, m_ien, m_ien & (m_fgi | m_fgo),
                ~m_fgi & enable & ~lsel, m_sending & enable & ~lsel, m_outr};
    endfunction

    task automatic idle_inputs();
        io.cpu_inp = 1'b0; io.cpu_out = 1'b0; io.cpu_ion = 1'b0;
        io.cpu_iof = 1'b0; io.cpu_int_ack = 1'b0;
        io.dev_in_valid = 1'b0; io.dev_out_ready = 1'b0;
    endtask

    // One clock: advance the model on the rising edge with the driven inputs, return at the falling edge.
    task automatic tick();
        logic       n_fgi;
        logic [7:0] n_inpr;
        @(posedge clk);
        if (enable) begin
            n_fgi  = m_fgi;
            n_inpr = m_inpr;
            if (io.dev_in_valid && !m_fgi && !lsel) begin
                n_inpr = io.dev_in_data;
                n_fgi  = 1'b1;
            end else if (io.cpu_inp && m_fgi) begin
                n_fgi = 1'b0;
            end
            if (io.cpu_int_ack || io.cpu_iof) m_ien = 1'b0;
            else if (io.cpu_ion)              m_ien = 1'b1;
            if (m_fgo) begin
                if (io.cpu_out) begin
                    m_outr = io.ac_low; m_fgo = 1'b0; m_sending = 1'b1;
                end
            end else if (m_sending) begin
                if (lsel ? !m_fgi : io.dev_out_ready) begin
                    if (lsel) begin
                        n_inpr = m_outr; n_fgi = 1'b1;
                    end
                    m_sending = 1'b0;
                    if (OUT_LATENCY == 0) m_fgo = 1'b1;
                    else                  m_wait = OUT_LATENCY;
                end
            end else begin
                m_wait = m_wait - 1;
                if (m_wait == 0) m_fgo = 1'b1;
            end
            m_fgi  = n_fgi;
            m_inpr = n_inpr;
        end
        @(negedge clk);
    endtask

    // Bring the port back to idle with FGI clear; bounded so a stuck DUT cannot hang the run.
    task automatic drain();
        int n;
        idle_inputs();
        n = 0;
        while ((io.fgo_o !== 1'b1 || io.fgi_o !== 1'b0) && n < 300) begin
            io.dev_out_ready = 1'b1;
            io.cpu_inp       = 1'b1;
            tick();
            n++;
        end
        idle_inputs();
        checks++;
        if (io.fgo_o !== 1'b1 || io.fgi_o !== 1'b0) begin
            errors++;
            $display("FAIL drain: fgo=%b fgi=%b, required fgo=1 fgi=0 within 300 cycles", io.fgo_o, io.fgi_o);
        end
    endtask

    task automatic test_reset();
        io.ac_low = 8'hC3; io.cpu_out = 1'b1; io.cpu_ion = 1'b1;
        io.dev_in_data = 8'h99; io.dev_in_valid = 1'b1;
        tick();
        idle_inputs();
        // Mid-transfer asynchronous reset, checked before any clock edge.
        #1 clr = 1'b1;
        #1;
        checks++;
        if ({io.inpr_o, io.fgi_o, io.fgo_o, io.ien_o, io.irq_o, io.dev_out_valid, io.dev_in_ready}
            !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset: inpr=%h fgi=%b fgo=%b ien=%b irq=%b dov=%b dir=%b, required 00 0 1 0 0 0 1",
                     io.inpr_o, io.fgi_o, io.fgo_o, io.ien_o, io.irq_o, io.dev_out_valid, io.dev_in_ready);
        end
        #2 clr = 1'b0;
        model_reset();
        tick();
        checks++;
        if (io.dev_out_data !== 8'h00 || io.dev_out_valid !== 1'b0 || io.fgo_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_no_residue: data=%h dov=%b fgo=%b, required 00 0 1",
                     io.dev_out_data, io.dev_out_valid, io.fgo_o);
        end
    endtask

    task automatic test_input();
        io.dev_in_data = 8'h41; io.dev_in_valid = 1'b1;
        tick();
        io.dev_in_data = 8'h42;
        checks++;
        if ({io.fgi_o, io.inpr_o, io.dev_in_ready} !== {1'b1, 8'h41, 1'b0}) begin
            errors++;
            $display("FAIL input_load: fgi=%b inpr=%h ready=%b, required 1 41 0", io.fgi_o, io.inpr_o, io.dev_in_ready);
        end
        tick();
        checks++;
        if (io.inpr_o !== 8'h41) begin
            errors++;
            $display("FAIL input_blocked: inpr=%h, required 41", io.inpr_o);
        end
        io.cpu_inp = 1'b1;
        tick();
        io.cpu_inp = 1'b0;
        checks++;
        if (io.fgi_o !== 1'b0 || io.dev_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL input_inp_clear: fgi=%b ready=%b, required 0 1", io.fgi_o, io.dev_in_ready);
        end
        tick();
        io.dev_in_valid = 1'b0;
        checks++;
        if (io.fgi_o !== 1'b1 || io.inpr_o !== 8'h42) begin
            errors++;
            $display("FAIL input_second: fgi=%b inpr=%h, required 1 42", io.fgi_o, io.inpr_o);
        end
        // INP with FGI clear coinciding with a load: the load wins.
        io.cpu_inp = 1'b1;
        tick();
        io.cpu_inp = 1'b1; io.dev_in_valid = 1'b1; io.dev_in_data = 8'h17;
        tick();
        idle_inputs();
        checks++;
        if (io.fgi_o !== 1'b1 || io.inpr_o !== 8'h17) begin
            errors++;
            $display("FAIL input_load_wins: fgi=%b inpr=%h, required 1 17", io.fgi_o, io.inpr_o);
        end
        drain();
    endtask

    task automatic test_output();
        io.ac_low = 8'h5A; io.cpu_out = 1'b1;
        tick();
        io.cpu_out = 1'b0;
        checks++;
        if ({io.dev_out_valid, io.dev_out_data, io.fgo_o} !== {1'b1, 8'h5A, 1'b0}) begin
            errors++;
            $display("FAIL output_start: valid=%b data=%h fgo=%b, required 1 5a 0",
                     io.dev_out_valid, io.dev_out_data, io.fgo_o);
        end
        for (int i = 0; i < 10; i++) begin
            io.cpu_out = (i == 3);
            io.ac_low  = 8'h33;
            tick();
            io.cpu_out = 1'b0;
            checks++;
            if (io.dev_out_valid !== 1'b1 || io.dev_out_data !== 8'h5A) begin
                errors++;
                $display("FAIL output_hold[%0d]: valid=%b data=%h, required 1 5a", i, io.dev_out_valid, io.dev_out_data);
            end
        end
        for (int k = 1; k <= 5; k++) begin
            io.dev_out_ready = (k == 1);
            tick();
            io.dev_out_ready = 1'b0;
            checks++;
            if (io.fgo_o !== 1'(k == 5)) begin
                errors++;
                $display("FAIL output_pace[%0d]: fgo=%b, required %b", k, io.fgo_o, 1'(k == 5));
            end
        end
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL output_model: got %h required %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_interrupt();
        io.cpu_ion = 1'b1;
        tick();
        checks++;
        if (io.ien_o !== 1'b1 || io.irq_o !== 1'b1) begin
            errors++;
            $display("FAIL irq_ion: ien=%b irq=%b, required 1 1", io.ien_o, io.irq_o);
        end
        io.cpu_int_ack = 1'b1;
        tick();
        io.cpu_int_ack = 1'b0;
        checks++;
        if (io.ien_o !== 1'b0 || io.irq_o !== 1'b0) begin
            errors++;
            $display("FAIL irq_ack_priority: ien=%b irq=%b, required 0 0", io.ien_o, io.irq_o);
        end
        tick();
        io.cpu_iof = 1'b1;
        tick();
        io.cpu_iof = 1'b0;
        checks++;
        if (io.ien_o !== 1'b0) begin
            errors++;
            $display("FAIL irq_iof_priority: ien=%b, required 0", io.ien_o);
        end
        // IEN set but both flags clear: no request.
        io.cpu_out = 1'b1; io.ac_low = 8'hE1;
        tick();
        io.cpu_out = 1'b0;
        checks++;
        if (io.ien_o !== 1'b1 || io.irq_o !== 1'b0) begin
            errors++;
            $display("FAIL irq_no_flag: ien=%b irq=%b, required 1 0", io.ien_o, io.irq_o);
        end
        io.cpu_ion = 1'b0; io.cpu_iof = 1'b1;
        tick();
        drain();
    endtask

    task automatic test_enable_freeze();
        io.cpu_out = 1'b1; io.ac_low = 8'h21;
        tick();
        io.cpu_out = 1'b0; io.dev_out_ready = 1'b1;
        tick();
        io.dev_out_ready = 1'b0;
        tick();
        enable = 1'b0;
        io.dev_in_valid = 1'b1; io.dev_in_data = 8'hAB;
        for (int i = 0; i < 20; i++) begin
            io.cpu_ion = i[0];
            tick();
            checks++;
            if (io.fgo_o !== 1'b0 || io.dev_in_ready !== 1'b0 || io.fgi_o !== 1'b0 || dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL freeze[%0d]: got %h required %h", i, dut_vec(), exp_vec());
            end
        end
        idle_inputs();
        enable = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (io.fgo_o !== 1'(k == 3)) begin
                errors++;
                $display("FAIL unfreeze[%0d]: fgo=%b, required %b", k, io.fgo_o, 1'(k == 3));
            end
        end
    endtask

    task automatic test_back_to_back();
        io.dev_in_valid = 1'b1; io.dev_in_data = 8'h6C;
        tick();
        io.dev_in_valid = 1'b0;
        io.cpu_inp = 1'b1; io.cpu_out = 1'b1; io.ac_low = 8'h9D;
        tick();
        idle_inputs();
        checks++;
        if ({io.fgi_o, io.inpr_o, io.dev_out_valid, io.dev_out_data} !== {1'b0, 8'h6C, 1'b1, 8'h9D}) begin
            errors++;
            $display("FAIL both_strobes: fgi=%b inpr=%h valid=%b data=%h, required 0 6c 1 9d",
                     io.fgi_o, io.inpr_o, io.dev_out_valid, io.dev_out_data);
        end
        drain();
    endtask

`ifdef MANO_IO_LOOPBACK_EN
    task automatic test_loopback();
        lsel = 1'b1;
        io.cpu_out = 1'b1; io.ac_low = 8'h7E;
        for (int k = 1; k <= 2; k++) begin
            tick();
            io.cpu_out = 1'b0;
            checks++;
            if (io.dev_out_valid !== 1'b0 || io.dev_in_ready !== 1'b0) begin
                errors++;
                $display("FAIL loop_no_dev[%0d]: valid=%b ready=%b, required 0 0", k, io.dev_out_valid, io.dev_in_ready);
            end
        end
        checks++;
        if (io.fgi_o !== 1'b1 || io.inpr_o !== 8'h7E) begin
            errors++;
            $display("FAIL loop_data: fgi=%b inpr=%h, required 1 7e", io.fgi_o, io.inpr_o);
        end
        drain();
        lsel = 1'b0;
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            enable           = ($urandom_range(7) != 0);
            io.cpu_inp       = ($urandom_range(3) == 0);
            io.cpu_out       = ($urandom_range(4) == 0);
            io.cpu_ion       = ($urandom_range(7) == 0);
            io.cpu_iof       = ($urandom_range(11) == 0);
            io.cpu_int_ack   = ($urandom_range(15) == 0);
            io.ac_low        = 8'($urandom);
            io.dev_in_data   = 8'($urandom);
            io.dev_in_valid  = ($urandom_range(2) == 0);
            io.dev_out_ready = ($urandom_range(1) == 0);
`ifdef MANO_IO_LOOPBACK_EN
            lsel             = ($urandom_range(3) == 0);
`endif
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random[%0d]: got %h required %h", c, dut_vec(), exp_vec());
            end
        end
        enable = 1'b1;
        lsel   = 1'b0;
        drain();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        enable = 1'b1;
        lsel   = 1'b0;
        io.ac_low = 8'h00;
        io.dev_in_data = 8'h00;
        idle_inputs();
        clr = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        clr = 1'b0;
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_state: got %h required %h", dut_vec(), exp_vec());
        end
        test_reset();
        test_input();
        test_output();
        test_interrupt();
        test_enable_freeze();
        test_back_to_back();
`ifdef MANO_IO_LOOPBACK_EN
        test_loopback();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
